cajero_param: RTL

Parametrised ATM session controller, the successor to the fixed 4-digit cajero FSM. It does the following:
- Accepts a card.
- Collects a PIN_DIGITS-digit BCD PIN one strobed digit at a time and compares it against the stored PIN.
- Counts failed attempts up to MAX_INTENTOS, then locks.
- Executes one deposit or withdrawal against a BALANCE_W-bit balance loaded at card insertion.
It sits between the keypad/card front end and the account/dispenser back end.

---
 rtl/cajero_param.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cajero_param.sv
// ATM session controller: card capture, PIN_DIGITS-digit BCD PIN check with
// attempt lockout, and one deposit/withdrawal per card against a saturating balance.
module cajero_param #(
  parameter int PIN_DIGITS   = 4,
  parameter int MAX_INTENTOS = 3,
  parameter int BALANCE_W    = 32,
  parameter int MONTO_W      = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic [BALANCE_W-1:0]    balance_inicial,
  input  logic                    digito_stb,
  input  logic [3:0]              digito,
  input  logic [4*PIN_DIGITS-1:0] pin,
  input  logic                    monto_stb,
  input  logic [MONTO_W-1:0]      monto,
  input  logic                    tipo_trans,
  output logic [BALANCE_W-1:0]    balance_actualizado,
  output logic                    balance_stb,
  output logic                    entregar_dinero,
  output logic                    pin_incorrecto,
  output logic                    advertencia,
  output logic                    bloqueo,
  output logic                    fondos_insuficientes
);

  localparam int PW = 4 * PIN_DIGITS;
  localparam int SW = BALANCE_W + 1;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_PIN  = 5'b00010;
  localparam logic [4:0] S_CMP  = 5'b00100;
  localparam logic [4:0] S_TRX  = 5'b01000;
  localparam logic [4:0] S_BLQ  = 5'b10000;

  logic [4:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [PW-1:0]        pin_rec_q, pin_rec_d;
  logic [3:0]           intentos_q, intentos_d;
  logic [BALANCE_W-1:0] bal_q, bal_d;
  logic                 bstb_q, bstb_d;
  logic                 entregar_q, entregar_d;
  logic                 pin_inc_q, pin_inc_d;
  logic                 adv_q, adv_d;
  logic                 bloq_q, bloq_d;
  logic                 fondos_q, fondos_d;

  logic [SW-1:0]        suma;
  logic [BALANCE_W-1:0] monto_ext;
  logic [3:0]           intentos_inc;

  // Shift-in works for any PIN_DIGITS, including a single-digit PIN.
  assign suma         = {1'b0, bal_q} + SW'(monto);
  assign monto_ext    = BALANCE_W'(monto);
  assign intentos_inc = intentos_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pin_rec_d  = pin_rec_q;
    intentos_d = intentos_q;
    bal_d      = bal_q;
    adv_d      = adv_q;
    bloq_d     = bloq_q;
    bstb_d     = 1'b0;
    entregar_d = 1'b0;
    pin_inc_d  = 1'b0;
    fondos_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tarjeta_recibida) begin
          bal_d     = balance_inicial;
          cnt_d     = 4'd0;
          pin_rec_d = '0;
          state_d   = S_PIN;
        end
      end
      S_PIN: begin
        if (digito_stb && (digito <= 4'd9)) begin
          pin_rec_d = (pin_rec_q << 4) | PW'(digito);
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == 4'(PIN_DIGITS)) state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (pin_rec_q == pin) begin
          intentos_d = 4'd0;
          adv_d      = 1'b0;
          state_d    = S_TRX;
        end else begin
          pin_inc_d  = 1'b1;
          intentos_d = intentos_inc;
          if (intentos_inc == 4'(MAX_INTENTOS)) begin
            adv_d   = 1'b0;
            bloq_d  = 1'b1;
            state_d = S_BLQ;
          end else begin
            if (intentos_inc == 4'(MAX_INTENTOS - 1)) adv_d = 1'b1;
            cnt_d     = 4'd0;
            pin_rec_d = '0;
            state_d   = S_PIN;
          end
        end
      end
      S_TRX: begin
        if (monto_stb) begin
          bstb_d  = 1'b1;
          state_d = S_IDLE;
          if (!tipo_trans) begin
            bal_d = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
          end else if (monto_ext <= bal_q) begin
            bal_d      = bal_q - monto_ext;
            entregar_d = 1'b1;
          end else begin
            fondos_d = 1'b1;
          end
        end
      end
      S_BLQ: state_d = S_BLQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pin_rec_q  <= '0;
      intentos_q <= 4'd0;
      bal_q      <= '0;
      bstb_q     <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pin_rec_q  <= pin_rec_d;
      intentos_q <= intentos_d;
      bal_q      <= bal_d;
      bstb_q     <= bstb_d;
      entregar_q <= entregar_d;
      pin_inc_q  <= pin_inc_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      fondos_q   <= fondos_d;
    end
  end

  assign balance_actualizado  = bal_q;
  assign balance_stb          = bstb_q;
  assign entregar_dinero      = entregar_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = bloq_q;
  assign fondos_insuficientes = fondos_q;

endmodule
